carregador_hd: RTL and testbench
================================

# carregador_hd

Transfer controller that reads one program from the HD store and streams it word by word into the instruction memory's load port. It is the writer side of the instruction-memory load interface: it drives the instruction word, the save-strobe, and the end-of-read strobe that the instruction memory samples on the falling clock edge. It also drives the HD read port. The SO/BIOS `lfhd` path starts it with a program number and waits on `ocupado`.

## Interface
- `TAM_TRILHA`, 256: HD words reserved per program slot; slot base = `numeroPrograma * TAM_TRILHA`.
- `TAM_BLOCO`, 200: maximum program length in words; matches the instruction-memory block size.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `iniciar`  in  1  start request; sampled only in IDLE.
- `numeroPrograma`  in  32  HD slot to load; latched when `iniciar` is accepted.
- `enderecoHD`  out  32  HD read address, registered.
- `dadoHD`  in  32  HD read data. `dadoHD` after edge t = mem[`enderecoHD` presented during the cycle before edge t]; one-cycle registered read.
- `entradaDeInstrucao`  out  32  instruction word to instruction memory, registered.
- `controleSalvaInstrucao`  out  2  2'b01 = write `entradaDeInstrucao` this cycle; otherwise 2'b00.
- `ControleFimDeLeitura`  out  2  2'b01 for one cycle = program complete, advance cursor; otherwise 2'b00.
- `ocupado`  out  1  transfer in progress.
- `erro`  out  1  one-cycle pulse: header length invalid.
- `palavrasTransferidas`  out  32  words written in the current or last transfer.

## Operation
- HD slot layout: word base+0 = length N; words base+1 .. base+N = instructions in order.
- Valid length: 1 ≤ N ≤ `TAM_BLOCO`.
- States: IDLE, LE_CAB, ESPERA_CAB, TRANSFERE, FIM, ERRO.
- IDLE, `iniciar`=1: latch base; `enderecoHD`←base; `ocupado`←1; `palavrasTransferidas`←0; go to LE_CAB.
- LE_CAB: `enderecoHD`←base+1; go to ESPERA_CAB.
- ESPERA_CAB: sample `dadoHD` as N.
  - N invalid: go to ERRO.
  - N valid: latch N; `enderecoHD`←base+2; go to TRANSFERE.
- TRANSFERE, each cycle:
  - `entradaDeInstrucao`←`dadoHD`; `controleSalvaInstrucao`←01; `palavrasTransferidas`++; `enderecoHD`++.
  - When the count reaches N, go to FIM.
- FIM: `controleSalvaInstrucao`←00; `ControleFimDeLeitura`←01; `entradaDeInstrucao` holds the last word; go to IDLE.
- ERRO: `erro`←1 for one cycle. No save strobe and no end strobe, so the cursor is not advanced. Go to IDLE.
- On entry to IDLE: `ocupado`, `ControleFimDeLeitura`, and `erro` return to 0.
- `controleSalvaInstrucao` and `ControleFimDeLeitura` are never 01 in the same cycle.
- Arithmetic: all 32-bit, wrap-around modulo 2^32. The base product is truncated to 32 bits and is not range-checked.
- `iniciar` while `ocupado`=1 is ignored and is not queued.
- `iniciar` held high: a new transfer starts on the first IDLE cycle after the previous one completes.

## Timing
- Reset values: every output is 0, state is IDLE, the latched N and base are 0.
- Reset mid-transfer: on the next edge everything is at reset values. No `ControleFimDeLeitura` pulse is issued. The partially written block is abandoned.
- Outputs change only on the rising edge, so they are stable at the instruction memory's falling-edge sample.
- Edge timeline for `iniciar` accepted at edge t0:
  - t0: LE_CAB, `ocupado`=1, address = base.
  - t1: ESPERA_CAB, address = base+1.
  - t2: N is sampled; enter TRANSFERE or ERRO.
  - t3 .. t2+N: word k is presented after edge t2+k with save=01. This gives exactly N consecutive save cycles.
  - t3+N: FIM, end=01, save=00.
  - t4+N: IDLE, `ocupado`=0.
- Total busy time is N+4 cycles.
- Error path: `erro` is high for the cycle after t3; `ocupado` falls at t4.

## Test plan
- Slot 2, N=3, words A,B,C, `TAM_TRILHA`=256 -> reads from 512, 513, ...; save=01 for exactly 3 cycles carrying A, B, C; then one end=01 cycle; `palavrasTransferidas`=3; `ocupado` high for 7 cycles.
- N=0 and N=201 -> `erro` pulses once; save and end stay 00 throughout; `ocupado` high for 4 cycles.
- N=200 (boundary) -> 200 consecutive save cycles, then end=01; data matches the HD contents in order.
- `reset` asserted at the 2nd save cycle of an N=5 load -> next cycle all outputs are 0; no end pulse; a following `iniciar` restarts cleanly from the header.
- `iniciar` pulsed mid-transfer -> ignored. `iniciar` held high across two loads -> second transfer begins on the first IDLE cycle; each load gets exactly one end pulse.
- N=1 -> a single save cycle immediately followed by the end cycle; save and end never both 01 in the same cycle.

Source files
------------

// File: rtl/carregador_hd.sv
// carregador_hd: streams one program from the HD store into the instruction memory load port
module carregador_hd #(
    parameter int TAM_TRILHA = 256,
    parameter int TAM_BLOCO  = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [31:0] numeroPrograma,
    output logic [31:0] enderecoHD,
    input  logic [31:0] dadoHD,
    output logic [31:0] entradaDeInstrucao,
    output logic [1:0]  controleSalvaInstrucao,
    output logic [1:0]  ControleFimDeLeitura,
    output logic        ocupado,
    output logic        erro,
    output logic [31:0] palavrasTransferidas
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LE_CAB     = 3'd1;
    localparam logic [2:0] ESPERA_CAB = 3'd2;
    localparam logic [2:0] TRANSFERE  = 3'd3;
    localparam logic [2:0] FIM        = 3'd4;
    localparam logic [2:0] ERRO       = 3'd5;

    logic [2:0]  estado;
    logic [31:0] base;
    logic [31:0] tamanho;
    logic [31:0] base_nova;
    logic        n_valido;
    logic [31:0] proxima_contagem;

    // slot base, header validity and next word count
    always_comb begin
        base_nova        = numeroPrograma * 32'(TAM_TRILHA);
        n_valido         = (dadoHD != 32'd0) && (dadoHD <= 32'(TAM_BLOCO));
        proxima_contagem = palavrasTransferidas + 32'd1;
    end

    // transfer sequencer; every output is a register so it is stable for the falling-edge sample
    always_ff @(posedge clock) begin
        if (reset) begin
            estado                 <= IDLE;
            base                   <= '0;
            tamanho                <= '0;
            enderecoHD             <= '0;
            entradaDeInstrucao     <= '0;
            controleSalvaInstrucao <= 2'b00;
            ControleFimDeLeitura   <= 2'b00;
            ocupado                <= 1'b0;
            erro                   <= 1'b0;
            palavrasTransferidas   <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    controleSalvaInstrucao <= 2'b00;
                    ControleFimDeLeitura   <= 2'b00;
                    erro                   <= 1'b0;
                    ocupado                <= iniciar;
                    if (iniciar) begin
                        base                 <= base_nova;
                        enderecoHD           <= base_nova;
                        palavrasTransferidas <= '0;
                        estado               <= LE_CAB;
                    end
                end
                LE_CAB: begin
                    enderecoHD <= base + 32'd1;
                    estado     <= ESPERA_CAB;
                end
                ESPERA_CAB: begin
                    if (n_valido) begin
                        tamanho    <= dadoHD;
                        enderecoHD <= base + 32'd2;
                        estado     <= TRANSFERE;
                    end else begin
                        estado <= ERRO;
                    end
                end
                TRANSFERE: begin
                    entradaDeInstrucao     <= dadoHD;
                    controleSalvaInstrucao <= 2'b01;
                    palavrasTransferidas   <= proxima_contagem;
                    enderecoHD             <= enderecoHD + 32'd1;
                    if (proxima_contagem == tamanho)
                        estado <= FIM;
                end
                FIM: begin
                    controleSalvaInstrucao <= 2'b00;
                    ControleFimDeLeitura   <= 2'b01;
                    estado                 <= IDLE;
                end
                ERRO: begin
                    erro   <= 1'b1;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_carregador_hd.sv
// tb_carregador_hd: directed checks of carregador_hd against a small HD model
module tb_carregador_hd;
    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [31:0] numeroPrograma;
    logic [31:0] enderecoHD;
    logic [31:0] dadoHD;
    logic [31:0] entradaDeInstrucao;
    logic [1:0]  controleSalvaInstrucao;
    logic [1:0]  ControleFimDeLeitura;
    logic        ocupado;
    logic        erro;
    logic [31:0] palavrasTransferidas;

    logic [31:0] hd [0:2047];
    int total = 0;
    int passou = 0;

    carregador_hd dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .numeroPrograma(numeroPrograma),
        .enderecoHD(enderecoHD),
        .dadoHD(dadoHD),
        .entradaDeInstrucao(entradaDeInstrucao),
        .controleSalvaInstrucao(controleSalvaInstrucao),
        .ControleFimDeLeitura(ControleFimDeLeitura),
        .ocupado(ocupado),
        .erro(erro),
        .palavrasTransferidas(palavrasTransferidas)
    );

    always #5 clock = ~clock;

    // HD store with one-cycle registered read
    always @(posedge clock) dadoHD <= hd[enderecoHD[10:0]];

    task automatic verifica(input string tag, input logic [127:0] obs, input logic [127:0] esp);
        total++;
        if (obs === esp) passou++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    endtask

    task automatic carrega(input int slot, input int n, input bit invalido, input bit pulso_meio);
        int cyc = 0, saves = 0, ends = 0, erros = 0, conflitos = 0, dados_err = 0;
        int prim = -1, ult = -1, fimc = -1;
        logic [31:0] base = 32'(slot) * 32'd256;
        logic [31:0] a0 = '0, a1 = '0;
        @(negedge clock);
        numeroPrograma = 32'(slot);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        while (ocupado && cyc < 400) begin
            if (cyc == 0) a0 = enderecoHD;
            if (cyc == 1) a1 = enderecoHD;
            if (pulso_meio && cyc == 4) begin
                iniciar = 1'b1;
                numeroPrograma = 32'd7;
            end
            if (pulso_meio && cyc == 5) iniciar = 1'b0;
            if (controleSalvaInstrucao == 2'b01) begin
                if (saves == 0) prim = cyc;
                ult = cyc;
                if (entradaDeInstrucao !== hd[base + 1 + 32'(saves)]) dados_err++;
                saves++;
            end
            if (ControleFimDeLeitura == 2'b01) begin
                ends++;
                fimc = cyc;
            end
            if (erro) erros++;
            if (controleSalvaInstrucao == 2'b01 && ControleFimDeLeitura == 2'b01) conflitos++;
            cyc++;
            @(negedge clock);
        end
        verifica($sformatf("busy_s%0d", slot), cyc, invalido ? 4 : n + 4);
        verifica($sformatf("addr0_s%0d", slot), a0, base);
        verifica($sformatf("addr1_s%0d", slot), a1, base + 1);
        verifica($sformatf("saves_s%0d", slot), saves, invalido ? 0 : n);
        verifica($sformatf("ends_s%0d", slot), ends, invalido ? 0 : 1);
        verifica($sformatf("erro_s%0d", slot), erros, invalido ? 1 : 0);
        verifica($sformatf("conflito_s%0d", slot), conflitos, 0);
        verifica($sformatf("palavras_s%0d", slot), palavrasTransferidas, invalido ? 0 : n);
        if (!invalido) begin
            verifica($sformatf("dados_s%0d", slot), dados_err, 0);
            verifica($sformatf("contiguo_s%0d", slot), ult - prim + 1, n);
            verifica($sformatf("fim_pos_s%0d", slot), fimc, n + 3);
        end
        if (pulso_meio) begin
            repeat (2) @(negedge clock);
            verifica("ignora_iniciar", ocupado, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) hd[i] = 32'h0;
        hd[256] = 2;   hd[257] = 32'h11110001; hd[258] = 32'h11110002;
        hd[512] = 3;   hd[513] = 32'hAAAA0001; hd[514] = 32'hBBBB0002; hd[515] = 32'hCCCC0003;
        hd[768] = 5;
        for (int i = 1; i <= 5; i++) hd[768 + i] = 32'h30300000 + 32'(i);
        hd[1024] = 0;
        hd[1280] = 201;
        hd[1536] = 200;
        for (int i = 1; i <= 200; i++) hd[1536 + i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
        hd[1792] = 1;  hd[1793] = 32'hDEADBEEF;

        reset = 1'b1;
        iniciar = 1'b0;
        numeroPrograma = '0;
        repeat (3) @(negedge clock);
        verifica("reset_saidas",
                 {enderecoHD, entradaDeInstrucao, controleSalvaInstrucao, ControleFimDeLeitura,
                  ocupado, erro, palavrasTransferidas}, 102'd0);
        reset = 1'b0;

        carrega(2, 3, 1'b0, 1'b0);
        carrega(4, 0, 1'b1, 1'b0);
        carrega(5, 201, 1'b1, 1'b0);
        carrega(6, 200, 1'b0, 1'b0);
        carrega(7, 1, 1'b0, 1'b0);
        carrega(3, 5, 1'b0, 1'b1);

        // reset on the second save cycle of an N=5 load
        begin
            int saves = 0, ends = 0, guarda = 0;
            @(negedge clock);
            numeroPrograma = 32'd3;
            iniciar = 1'b1;
            @(negedge clock);
            iniciar = 1'b0;
            while (saves < 2 && guarda < 50) begin
                if (controleSalvaInstrucao == 2'b01) saves++;
                if (saves < 2) @(negedge clock);
                guarda++;
            end
            verifica("reset_alcancado", saves, 2);
            reset = 1'b1;
            @(negedge clock);
            verifica("reset_meio",
                     {enderecoHD, entradaDeInstrucao, controleSalvaInstrucao, ControleFimDeLeitura,
                      ocupado, erro, palavrasTransferidas}, 102'd0);
            reset = 1'b0;
            repeat (4) begin
                @(negedge clock);
                if (ControleFimDeLeitura == 2'b01) ends++;
            end
            verifica("reset_sem_fim", ends, 0);
            verifica("reset_ocioso", ocupado, 1'b0);
        end
        carrega(3, 5, 1'b0, 1'b0);

        // iniciar held high across two back-to-back loads of slot 1 (N=2)
        begin
            int cyc = 0, ends = 0, saves = 0, f0 = -1, f1 = -1;
            logic [31:0] a2 = '0;
            @(negedge clock);
            numeroPrograma = 32'd1;
            iniciar = 1'b1;
            @(negedge clock);
            while (ocupado && cyc < 100) begin
                if (cyc == 6) begin
                    iniciar = 1'b0;
                    a2 = enderecoHD;
                end
                if (controleSalvaInstrucao == 2'b01) saves++;
                if (ControleFimDeLeitura == 2'b01) begin
                    if (ends == 0) f0 = cyc;
                    else f1 = cyc;
                    ends++;
                end
                cyc++;
                @(negedge clock);
            end
            verifica("held_busy", cyc, 12);
            verifica("held_ends", ends, 2);
            verifica("held_fim0", f0, 5);
            verifica("held_fim1", f1, 11);
            verifica("held_addr2", a2, 32'd256);
            verifica("held_saves", saves, 4);
        end

        $display("%0d/%0d checks passed", passou, total);
        $finish;
    end
endmodule
